// File: rtl/imm_ext_arbiter.sv
// Two-requester immediate extension unit: round-robin grant, one-cycle
// registered result with ack pulse back to the winning requester.
module imm_ext_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        req0,
  input  logic [7:0]  imm0,
  input  logic [1:0]  mode0,
  input  logic        req1,
  input  logic [7:0]  imm1,
  input  logic [1:0]  mode1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] r,
  output logic        r_valid,
  output logic        r_id
);

  localparam logic [1:0] MODE_SEXT  = 2'b00;
  localparam logic [1:0] MODE_ZEXT  = 2'b01;
  localparam logic [1:0] MODE_BOFF  = 2'b10;
  localparam logic [1:0] MODE_UPPER = 2'b11;

  function automatic logic [15:0] ext_imm(input logic [7:0] imm, input logic [1:0] mode);
    logic signed [7:0]  simm;
    logic signed [15:0] sx;
    logic [15:0]        res;
    simm = imm;
    sx   = simm;
    res  = 16'h0000;
    case (mode)
      MODE_SEXT:  res = sx;
      MODE_ZEXT:  res = {8'h00, imm};
      MODE_BOFF:  res = sx <<< 1;
      MODE_UPPER: res = {imm, 8'h00};
      default:    res = 16'h0000;
    endcase
    return res;
  endfunction

  // ptr = 1 means requester 1 wins a tie
  logic        ptr;
  logic        elig0_p0, elig1_p0;
  logic        grant0_p0, grant1_p0;
  logic [15:0] ext_p0;

  // Stage p0: eligibility masks the requester acked this cycle, then arbitrate
  always_comb begin
    elig0_p0  = req0 & ~ack0;
    elig1_p0  = req1 & ~ack1;
    grant0_p0 = elig0_p0 & (~elig1_p0 | ~ptr);
    grant1_p0 = elig1_p0 & (~elig0_p0 | ptr);
    ext_p0    = grant1_p0 ? ext_imm(imm1, mode1) : ext_imm(imm0, mode0);
  end

  // Stage p1: registered result, owner and ack pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= 16'h0000;
      r_valid <= 1'b0;
      r_id    <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      ptr     <= 1'b0;
    end else if (hold) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else if (grant0_p0 || grant1_p0) begin
      r       <= ext_p0;
      r_valid <= 1'b1;
      r_id    <= grant1_p0;
      ack0    <= grant0_p0;
      ack1    <= grant1_p0;
      ptr     <= grant0_p0;
    end else begin
      r_valid <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: behavioural model compared every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  imm0 = 8'h00, imm1 = 8'h00;
  logic [1:0]  mode0 = 2'b00, mode1 = 2'b00;
  logic        ack0, ack1, r_valid, r_id;
  logic [15:0] r;

  int errors = 0;
  int checks = 0;

  imm_ext_arbiter dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0(req0), .imm0(imm0), .mode0(mode0),
    .req1(req1), .imm1(imm1), .mode1(mode1),
    .ack0(ack0), .ack1(ack1), .r(r), .r_valid(r_valid), .r_id(r_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: extension by plain arithmetic, arbitration by preferred index
  function automatic logic [15:0] model_ext(input int imm, input int mode);
    int sv;
    sv = (imm >= 128) ? imm - 256 : imm;
    case (mode)
      0:       return 16'((sv + 65536) % 65536);
      1:       return 16'(imm);
      2:       return 16'((sv * 2 + 65536) % 65536);
      default: return 16'(imm * 256);
    endcase
  endfunction

  logic [15:0] m_r;
  logic        m_valid, m_id;
  logic        m_ack [2];
  int          m_pref;

  initial begin
    int n_elig, win;
    bit e [2];
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_r = 16'h0; m_valid = 0; m_id = 0; m_ack[0] = 0; m_ack[1] = 0; m_pref = 0;
      end else if (hold) begin
        m_ack[0] = 0; m_ack[1] = 0;
      end else begin
        e[0] = req0 && !m_ack[0];
        e[1] = req1 && !m_ack[1];
        n_elig = int'(e[0]) + int'(e[1]);
        m_ack[0] = 0; m_ack[1] = 0;
        if (n_elig == 0) begin
          m_valid = 0;
        end else begin
          win = (n_elig == 2) ? m_pref : (e[1] ? 1 : 0);
          m_r = (win == 1) ? model_ext(imm1, mode1) : model_ext(imm0, mode0);
          m_valid = 1;
          m_id = (win == 1);
          m_ack[win] = 1;
          m_pref = 1 - win;
        end
      end
      #1;
      check("model_r", r, m_r);
      check("model_r_valid", 16'(r_valid), 16'(m_valid));
      check("model_r_id", 16'(r_id), 16'(m_id));
      check("model_ack0", 16'(ack0), 16'(m_ack[0]));
      check("model_ack1", 16'(ack1), 16'(m_ack[1]));
      check("ack_exclusive", 16'(ack0 & ack1), 16'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0]  t_imm [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
  logic [1:0]  t_mode[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  logic [15:0] t_exp [5] = '{16'hFFFF, 16'h00FF, 16'hFFFE, 16'hFF00, 16'h007F};

  initial begin
    logic [15:0] r_saved;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_r", r, 16'h0000);
    check("rst_valid", 16'(r_valid), 16'h0);
    check("rst_acks", 16'({ack1, ack0}), 16'h0);
    rst_n = 1'b1;

    // extension modes on requester 0 alone
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); req0 = 1; imm0 = t_imm[i]; mode0 = t_mode[i];
      tick();
      check("mode_r", r, t_exp[i]);
      check("mode_ack0", 16'(ack0), 16'h1);
      check("mode_id", 16'(r_id), 16'h0);
      @(negedge clk); req0 = 0;
      tick();
      check("mode_ack0_off", 16'(ack0), 16'h0);
      check("mode_valid_off", 16'(r_valid), 16'h0);
    end

    // operand changes without req leave outputs alone
    @(negedge clk); imm0 = 8'h12; mode0 = 2'b11; imm1 = 8'h34;
    tick();
    check("noreq_r", r, 16'h007F);

    // simultaneous requests after a fresh reset
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    req0 = 1; imm0 = 8'h80; mode0 = 2'b00; req1 = 1; imm1 = 8'h05; mode1 = 2'b10;
    tick();
    check("sim_ack0", 16'(ack0), 16'h1);
    check("sim_r0", r, 16'hFF80);
    check("sim_id0", 16'(r_id), 16'h0);
    @(negedge clk); req0 = 0;
    tick();
    check("sim_ack1", 16'(ack1), 16'h1);
    check("sim_r1", r, 16'h000A);
    check("sim_id1", 16'(r_id), 16'h1);
    @(negedge clk); req1 = 0;
    tick();
    check("sim_valid_off", 16'(r_valid), 16'h0);

    // continuous contention alternates 0,1,0,1,0,1
    @(negedge clk); req0 = 1; req1 = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("alt_ack0", 16'(ack0), 16'((k % 2) == 0));
      check("alt_ack1", 16'(ack1), 16'((k % 2) == 1));
    end
    // one more grant to 0, then hold for 3 edges
    tick();
    check("pre_hold_ack0", 16'(ack0), 16'h1);
    r_saved = r;
    @(negedge clk); hold = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_r", r, r_saved);
      check("hold_valid", 16'(r_valid), 16'h1);
      check("hold_id", 16'(r_id), 16'h0);
      check("hold_acks", 16'({ack1, ack0}), 16'h0);
    end
    @(negedge clk); hold = 0;
    tick();
    check("post_hold_ack1", 16'(ack1), 16'h1);
    check("post_hold_r", r, 16'h000A);
    @(negedge clk); req0 = 0; req1 = 0;
    tick();

    // single requester held high: served every second cycle
    @(negedge clk); req1 = 1; imm1 = 8'h81; mode1 = 2'b01;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("single_valid", 16'(r_valid), 16'((k % 2) == 0));
      check("single_ack1", 16'(ack1), 16'((k % 2) == 0));
    end
    @(negedge clk); req1 = 0;
    tick();

    // reset mid-cycle while a result is valid
    @(negedge clk); req0 = 1; imm0 = 8'h01; mode0 = 2'b11; req1 = 1; imm1 = 8'h02; mode1 = 2'b00;
    @(posedge clk); #3;
    check("pre_rst_valid", 16'(r_valid), 16'h1);
    rst_n = 0;
    #1;
    check("async_rst_r", r, 16'h0000);
    check("async_rst_valid", 16'(r_valid), 16'h0);
    check("async_rst_acks", 16'({ack1, ack0}), 16'h0);
    @(negedge clk); rst_n = 1;
    tick();
    check("post_rst_ack0", 16'(ack0), 16'h1);
    check("post_rst_r", r, 16'h0100);
    @(negedge clk); req0 = 0; req1 = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
